// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin transmit scheduler for the UART frame generator
// Grants one of two byte sources per frame, then paces the frame with bit-period ticks.
module uart_tx_sched #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    input  logic       cfg_parity,
    input  logic       cfg_8bit,
    input  logic       fg_busy,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] fg_data,
    output logic       fg_enable,
    output logic       fg_sw0,
    output logic       fg_sw1,
    output logic       fg_delay_done,
    output logic       tx_active,
    output logic       err_timeout
);
    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, SEND, DRAIN} state_t;

    localparam logic [15:0] BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [7:0]  TMO_LIMIT  = 8'(BUSY_TIMEOUT);
    localparam logic [3:0]  LAST_TICK  = 4'd10;

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        last_grant_q, last_grant_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic [7:0]  fg_data_q, fg_data_d;
    logic        fg_enable_q, fg_enable_d;
    logic        fg_sw0_q, fg_sw0_d, fg_sw1_q, fg_sw1_d;
    logic        fg_delay_done_q, fg_delay_done_d;
    logic        tx_active_q, tx_active_d;
    logic        err_timeout_q, err_timeout_d;

    logic [7:0]  tmo_inc;
    logic        baud_term;
    logic        grant1;

    assign tmo_inc   = tmo_q + 8'd1;
    assign baud_term = (baud_q == BAUD_LAST);

    always_comb begin
        state_d         = state_q;
        baud_d          = baud_q;
        tick_cnt_d      = tick_cnt_q;
        tmo_d           = tmo_q;
        last_grant_d    = last_grant_q;
        ack0_d          = 1'b0;
        ack1_d          = 1'b0;
        fg_enable_d     = 1'b0;
        fg_delay_done_d = 1'b0;
        fg_data_d       = fg_data_q;
        fg_sw0_d        = fg_sw0_q;
        fg_sw1_d        = fg_sw1_q;
        err_timeout_d   = err_timeout_q;
        // On a tie the source that did not win last time gets the frame
        grant1          = (req0 && req1) ? !last_grant_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    fg_data_d     = grant1 ? data1 : data0;
                    fg_sw0_d      = cfg_parity;
                    fg_sw1_d      = cfg_8bit;
                    ack0_d        = !grant1;
                    ack1_d        = grant1;
                    fg_enable_d   = 1'b1;
                    last_grant_d  = grant1;
                    err_timeout_d = 1'b0;
                    state_d       = START;
                end
            end
            START: begin
                tmo_d   = 8'd0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (fg_busy) begin
                    baud_d     = 16'd0;
                    tick_cnt_d = 4'd0;
                    state_d    = SEND;
                end else if (tmo_inc == TMO_LIMIT) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            SEND: begin
                // Busy may drop together with the stop-bit tick, but not earlier
                if (!fg_busy && !(baud_term && tick_cnt_q == LAST_TICK)) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else if (baud_term) begin
                    baud_d          = 16'd0;
                    fg_delay_done_d = 1'b1;
                    tick_cnt_d      = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == LAST_TICK) begin
                        tmo_d   = 8'd0;
                        state_d = DRAIN;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DRAIN: begin
                if (!fg_busy) begin
                    state_d = IDLE;
                end else if (tmo_inc == TMO_LIMIT) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        tx_active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            baud_q          <= 16'd0;
            tick_cnt_q      <= 4'd0;
            tmo_q           <= 8'd0;
            last_grant_q    <= 1'b1;
            ack0_q          <= 1'b0;
            ack1_q          <= 1'b0;
            fg_data_q       <= 8'h00;
            fg_enable_q     <= 1'b0;
            fg_sw0_q        <= 1'b0;
            fg_sw1_q        <= 1'b0;
            fg_delay_done_q <= 1'b0;
            tx_active_q     <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            baud_q          <= baud_d;
            tick_cnt_q      <= tick_cnt_d;
            tmo_q           <= tmo_d;
            last_grant_q    <= last_grant_d;
            ack0_q          <= ack0_d;
            ack1_q          <= ack1_d;
            fg_data_q       <= fg_data_d;
            fg_enable_q     <= fg_enable_d;
            fg_sw0_q        <= fg_sw0_d;
            fg_sw1_q        <= fg_sw1_d;
            fg_delay_done_q <= fg_delay_done_d;
            tx_active_q     <= tx_active_d;
            err_timeout_q   <= err_timeout_d;
        end
    end

    assign ack0          = ack0_q;
    assign ack1          = ack1_q;
    assign fg_data       = fg_data_q;
    assign fg_enable     = fg_enable_q;
    assign fg_sw0        = fg_sw0_q;
    assign fg_sw1        = fg_sw1_q;
    assign fg_delay_done = fg_delay_done_q;
    assign tx_active     = tx_active_q;
    assign err_timeout   = err_timeout_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched
module tb_uart_tx_sched;
    localparam int CPB = 4;
    localparam int BT  = 8;

    typedef struct packed {
        logic       src;
        logic [7:0] data;
        logic       sw0;
        logic       sw1;
    } exp_t;

    logic       clk, rst;
    logic       req0, req1, cfg_parity, cfg_8bit, fg_busy;
    logic [7:0] data0, data1;
    logic       ack0, ack1, fg_enable, fg_sw0, fg_sw1, fg_delay_done, tx_active, err_timeout;
    logic [7:0] fg_data;

    logic       d2_req, d2_zero, d2_busy;
    logic [7:0] d2_data, d2_data1;
    logic       d2_ack0, d2_ack1, d2_en, d2_sw0, d2_sw1, d2_tick, d2_act, d2_err;
    logic [7:0] d2_fg_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    exp_t       exp_q[$];
    logic [1:0] cfg_plan[$];
    logic [7:0] src_q0[$], src_q1[$];
    logic [7:0] pend0[$], pend1[$];
    logic       m_last;
    int         gen_mode;

    int   frames_done = 0;
    int   f_ticks = 0;
    int   busy_rise_cyc = 0;
    logic in_frame = 0;

    uart_tx_sched #(.CLKS_PER_BIT(CPB), .BUSY_TIMEOUT(BT)) u_dut (
        .clk(clk), .rst(rst), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .cfg_parity(cfg_parity), .cfg_8bit(cfg_8bit), .fg_busy(fg_busy),
        .ack0(ack0), .ack1(ack1), .fg_data(fg_data), .fg_enable(fg_enable),
        .fg_sw0(fg_sw0), .fg_sw1(fg_sw1), .fg_delay_done(fg_delay_done),
        .tx_active(tx_active), .err_timeout(err_timeout)
    );

    uart_tx_sched #(.CLKS_PER_BIT(2), .BUSY_TIMEOUT(BT)) u_dut2 (
        .clk(clk), .rst(rst), .req0(d2_req), .data0(d2_data), .req1(d2_zero), .data1(d2_data1),
        .cfg_parity(cfg_parity), .cfg_8bit(cfg_8bit), .fg_busy(d2_busy),
        .ack0(d2_ack0), .ack1(d2_ack1), .fg_data(d2_fg_data), .fg_enable(d2_en),
        .fg_sw0(d2_sw0), .fg_sw1(d2_sw1), .fg_delay_done(d2_tick),
        .tx_active(d2_act), .err_timeout(d2_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference arbitration: alternate on ties, otherwise serve whoever still has bytes
    task automatic predict_pending(input int cfg_fixed);
        int         i0, i1;
        logic       g;
        logic [1:0] cf;
        exp_t       e;
        i0 = 0;
        i1 = 0;
        while (i0 < pend0.size() || i1 < pend1.size()) begin
            if (i0 < pend0.size() && i1 < pend1.size()) g = !m_last;
            else g = (i1 < pend1.size());
            e.src = g;
            if (g) begin e.data = pend1[i1]; i1++; end
            else   begin e.data = pend0[i0]; i0++; end
            cf = (cfg_fixed >= 0) ? 2'(cfg_fixed) : 2'($urandom);
            e.sw0 = cf[1];
            e.sw1 = cf[0];
            exp_q.push_back(e);
            cfg_plan.push_back(cf);
            m_last = g;
        end
    endtask

    task automatic load_pending();
        foreach (pend0[i]) src_q0.push_back(pend0[i]);
        foreach (pend1[i]) src_q1.push_back(pend1[i]);
        pend0.delete();
        pend1.delete();
    endtask

    task automatic wait_frames(input int n, input string name);
        int base;
        base = frames_done;
        for (int c = 0; c < 200 * n && frames_done < base + n; c++) @(negedge clk);
        check(name, frames_done - base, n);
    endtask

    // Byte sources: hold req while bytes remain; cfg shows the next frame's plan while idle
    // and random noise while a frame is in flight.
    initial begin
        req0 = 0; req1 = 0; data0 = 0; data1 = 0; cfg_parity = 0; cfg_8bit = 0;
        forever begin
            @(negedge clk);
            if (ack0 && src_q0.size() > 0) void'(src_q0.pop_front());
            if (ack1 && src_q1.size() > 0) void'(src_q1.pop_front());
            if ((ack0 || ack1) && cfg_plan.size() > 0) void'(cfg_plan.pop_front());
            req0  = (src_q0.size() > 0);
            data0 = req0 ? src_q0[0] : 8'h00;
            req1  = (src_q1.size() > 0);
            data1 = req1 ? src_q1[0] : 8'h00;
            if (tx_active) {cfg_parity, cfg_8bit} = 2'($urandom);
            else if (cfg_plan.size() > 0) {cfg_parity, cfg_8bit} = cfg_plan[0];
        end
    end

    // Frame generator model: busy one cycle after the enable pulse, released after 11 ticks
    initial begin
        int g_phase, g_ticks, g_drop;
        fg_busy = 0; g_phase = 0; g_ticks = 0; g_drop = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                fg_busy = 0; g_phase = 0; g_ticks = 0;
            end else begin
                case (g_phase)
                    0: if (fg_enable && gen_mode == 0) g_phase = 1;
                    1: begin fg_busy = 1; busy_rise_cyc = cyc; g_ticks = 0; g_phase = 2; end
                    2: if (fg_delay_done) begin
                        g_ticks++;
                        if (g_ticks == 11) begin g_drop = $urandom_range(1, 4); g_phase = 3; end
                    end
                    default: begin
                        g_drop--;
                        if (g_drop == 0) begin fg_busy = 0; g_phase = 0; end
                    end
                endcase
            end
        end
    end

    // Monitor: pops the scoreboard on every grant and checks frame pacing
    initial begin
        exp_t e, cur;
        logic prev_act, prev_en;
        int   last_tick_cyc, f_en_cyc;
        prev_act = 0; prev_en = 0; last_tick_cyc = 0; f_en_cyc = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_frame = 0; prev_act = 0; prev_en = 0; f_ticks = 0;
            end else begin
                if (fg_enable || ack0 || ack1) begin
                    check("enable_vs_ack", fg_enable, ack0 | ack1);
                    check("enable_one_cycle", prev_en, 0);
                end
                if (ack0 || ack1) begin
                    check("ack_exclusive", ack0 & ack1, 0);
                    check("idle_before_grant", prev_act, 0);
                    check("active_at_grant", tx_active, 1);
                    check("err_cleared_at_grant", err_timeout, 0);
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_ack: ack0=%0b ack1=%0b with no grant expected", ack0, ack1);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant_src", ack1, e.src);
                        check("fg_data", fg_data, e.data);
                        check("fg_sw0", fg_sw0, e.sw0);
                        check("fg_sw1", fg_sw1, e.sw1);
                        cur = e;
                    end
                    in_frame = 1; f_ticks = 0; f_en_cyc = cyc;
                end
                if (fg_delay_done) begin
                    check("tick_in_frame", in_frame && tx_active && fg_busy, 1);
                    if (f_ticks == 0) check("first_tick_latency", cyc - busy_rise_cyc, CPB + 1);
                    else check("tick_spacing", cyc - last_tick_cyc, CPB);
                    check("cfg_held_in_frame", {fg_sw0, fg_sw1, fg_data}, {cur.sw0, cur.sw1, cur.data});
                    f_ticks++;
                    last_tick_cyc = cyc;
                end
                if (prev_act && !tx_active) begin
                    check("ticks_per_frame", f_ticks, (gen_mode == 1) ? 0 : 11);
                    check("err_at_frame_end", err_timeout, (gen_mode == 1) ? 1 : 0);
                    if (gen_mode == 1)
                        check("timeout_latency", (cyc - f_en_cyc >= BT) && (cyc - f_en_cyc <= BT + 2), 1);
                    in_frame = 0;
                    frames_done++;
                end
                prev_act = tx_active;
                prev_en  = fg_enable;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, fr, tk, lastc, acks;
        logic d2_pend, d2_drop, pa;
        rst = 0; gen_mode = 0; m_last = 1'b1;
        d2_req = 0; d2_zero = 0; d2_busy = 0; d2_data = 8'h5A; d2_data1 = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_fg_data", fg_data, 8'h00);
        check("reset_pulses", {ack0, ack1, fg_enable, fg_delay_done}, 4'b0);
        check("reset_status", {fg_sw0, fg_sw1, tx_active, err_timeout}, 4'b0);
        rst = 1;
        @(negedge clk);

        // Single source 0 frame, 8-bit + parity
        pend0.push_back(8'hA5);
        predict_pending(3);
        load_pending();
        wait_frames(1, "frame_a5_done");

        // Both sources hold requests for four frames
        for (int i = 0; i < 2; i++) begin
            pend0.push_back(8'($urandom));
            pend1.push_back(8'($urandom));
        end
        predict_pending(-1);
        load_pending();
        wait_frames(4, "alternating_frames_done");

        // Random batches
        for (int b = 0; b < 6; b++) begin
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 + n1 == 0) n0 = 1;
            for (int i = 0; i < n0; i++) pend0.push_back(8'($urandom));
            for (int i = 0; i < n1; i++) pend1.push_back(8'($urandom));
            predict_pending(-1);
            load_pending();
            wait_frames(n0 + n1, "random_batch_done");
        end

        // Generator never asserts busy
        gen_mode = 1;
        pend0.push_back(8'($urandom));
        predict_pending(-1);
        load_pending();
        wait_frames(1, "timeout_frame_done");
        repeat (5) @(negedge clk);
        check("err_sticky", err_timeout, 1);
        check("idle_after_timeout", tx_active, 0);
        gen_mode = 0;
        pend1.push_back(8'($urandom));
        predict_pending(-1);
        load_pending();
        wait_frames(1, "frame_after_timeout_done");

        // Reset in the middle of SEND with both sources waiting
        pend0.push_back(8'h11);
        predict_pending(-1);
        load_pending();
        for (int c = 0; c < 500 && !(in_frame && f_ticks >= 5); c++) @(negedge clk);
        check("reached_5_ticks", f_ticks >= 5, 1);
        pend0.push_back(8'h22);
        pend1.push_back(8'h33);
        m_last = 1'b1;
        predict_pending(-1);
        load_pending();
        repeat (2) @(negedge clk);
        #2 rst = 0;
        #1;
        check("async_reset_fg_data", fg_data, 8'h00);
        check("async_reset_outputs",
              {ack0, ack1, fg_enable, fg_sw0, fg_sw1, fg_delay_done, tx_active, err_timeout}, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1;
        wait_frames(2, "frames_after_reset_done");
        check("scoreboard_drained", exp_q.size(), 0);

        // Two-clock bit period on the second instance
        fr = 0; tk = 0; lastc = 0; acks = 0; d2_pend = 0; d2_drop = 0; pa = 0;
        d2_req = 1;
        for (int c = 0; c < 300 && fr < 2; c++) begin
            @(negedge clk);
            if (d2_pend) begin d2_busy = 1; d2_pend = 0; end
            if (d2_drop) begin d2_busy = 0; d2_drop = 0; end
            if (d2_ack0) begin
                acks++;
                check("d2_fg_data", d2_fg_data, 8'h5A);
                tk = 0;
                if (acks == 2) d2_req = 0;
            end
            if (d2_en) d2_pend = 1;
            if (d2_tick) begin
                if (tk > 0) check("d2_tick_spacing", cyc - lastc, 2);
                lastc = cyc;
                tk++;
                if (tk == 11) d2_drop = 1;
            end
            if (pa && !d2_act) begin
                check("d2_ticks_per_frame", tk, 11);
                fr++;
            end
            pa = d2_act;
        end
        check("d2_frames", fr, 2);
        check("d2_acks", acks, 2);
        check("d2_no_error", {d2_err, d2_ack1}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler for the UART frame generator. Arbitrates two byte sources onto the single frame generator with round-robin fairness. Per frame it latches the parity/width configuration, issues the write enable and generates the bit-period `delay_done` ticks. It then waits for the generator to release busy before granting the next frame. It sits between the byte producers (host interface, loopback/test source) and the frame generator.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit; 16-bit counter; legal 2..65535.
- `BUSY_TIMEOUT`, 8: max cycles to wait for `fg_busy` to rise or fall; legal 2..255.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0` in 1: source 0 has a byte; level, held until `ack0`.
- `data0` in 8: source 0 byte; stable while `req0` is high.
- `req1` in 1: source 1 has a byte; level, held until `ack1`.
- `data1` in 8: source 1 byte.
- `cfg_parity` in 1: 1 = even parity, 0 = none; sampled at grant only.
- `cfg_8bit` in 1: 1 = 8 data bits, 0 = 7; sampled at grant only.
- `fg_busy` in 1: busy from the frame generator.
- `ack0` out 1: one-cycle pulse; `data0` captured.
- `ack1` out 1: one-cycle pulse; `data1` captured.
- `fg_data` out 8: byte to the generator; held for the whole frame.
- `fg_enable` out 1: one-cycle write-enable pulse to the generator.
- `fg_sw0` out 1: latched `cfg_parity`.
- `fg_sw1` out 1: latched `cfg_8bit`.
- `fg_delay_done` out 1: bit-period tick, one cycle wide.
- `tx_active` out 1: high in every state except IDLE.
- `err_timeout` out 1: sticky; the generator failed to raise or drop busy in time.

## Operation
- All outputs are registered. Reset value of every output is 0, `fg_data` = 8'h00. Internal `last_grant` resets to 1, so source 0 wins the first tie.
- FSM states: IDLE, START, WAIT_BUSY, SEND, DRAIN.
- IDLE, any req high:
  - Grant one source. With a single request, grant it. With both, grant `!last_grant`.
  - Capture `dataN` into `fg_data` and cfg into `fg_sw0`/`fg_sw1`. Pulse `ackN`, set `fg_enable`, update `last_grant`, clear `err_timeout`. Go to START.
- START: drop `fg_enable` (pulse is exactly 1 cycle). Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - `fg_busy` = 1: clear the baud counter and tick counter; go to SEND.
  - Timeout counter reaches `BUSY_TIMEOUT`: set `err_timeout`, go to IDLE, no ticks issued.
- SEND:
  - Baud counter counts 0..`CLKS_PER_BIT`-1. At terminal count, pulse `fg_delay_done` and wrap to 0.
  - After the 11th tick (start, parity/pad, 8 data, stop positions), go to DRAIN.
  - `fg_busy` falling before the 11th tick: set `err_timeout`, go to IDLE.
- DRAIN:
  - `fg_busy` = 0: go to IDLE.
  - Otherwise time out after `BUSY_TIMEOUT` cycles: set `err_timeout`, go to IDLE.
- Requests arriving mid-frame wait; no ack is issued outside IDLE.
- Config changes mid-frame have no effect until the next grant.
- Asynchronous reset mid-frame: outputs go to reset values immediately; any in-progress frame is abandoned.

## Timing
- Grant edge G: `ackN`/`fg_enable` high in cycle G+1. State is WAIT_BUSY from G+2.
- The generator asserts busy 2 cycles after the enable edge. Nominal WAIT_BUSY dwell is 1–2 cycles.
- First `fg_delay_done` comes `CLKS_PER_BIT` cycles after SEND entry. Ticks then repeat every `CLKS_PER_BIT` cycles; 11 ticks per frame.
- Frame length, grant to IDLE: 11·`CLKS_PER_BIT` + ~6 cycles.
- Minimum idle between frames: 1 cycle (IDLE → grant).
- A source holding `req` continuously gets back-to-back frames. With both requesting, grants strictly alternate.

## Test plan
- Single req0, `data0`=8'hA5, cfg 8-bit+parity, `CLKS_PER_BIT`=4:
  - `ack0` 1 cycle; `fg_enable` 1 cycle; `fg_data`=A5, `fg_sw0`=`fg_sw1`=1.
  - 11 `fg_delay_done` pulses spaced 4 cycles; `tx_active` falls after busy drops.
- req0 and req1 held high together for 4 frames: grant order 0,1,0,1; acks never overlap; no tick outside SEND.
- Toggle `cfg_8bit` mid-frame: `fg_sw1` unchanged until the next `ack`.
- Model holding `fg_busy`=0: `err_timeout`=1 `BUSY_TIMEOUT` cycles after START, zero ticks, back in IDLE. Next grant clears `err_timeout`.
- Assert `rst`=0 during SEND after 5 ticks: all outputs 0 asynchronously. After release, pending req0 is granted first.
- `CLKS_PER_BIT`=2 boundary: ticks every 2 cycles; exactly 11 per frame.
